// File: rtl/keypad_token_encoder.sv
// keypad_token_encoder
//   Input stage of the calculator datapath. It debounces 12 push switches,
//   turns debounced press edges into tokens (kind, BCD value, LCD character),
//   and buffers those tokens in a small FIFO for the calculator core.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   sample_en    single-clk strobe; debounce advances only when high
//   sw[11:0]     raw switches: [9:0] digits, [10] operator, [11] equals
//   op_sel[2:0]  operator selection, captured when an operator token is made
//   tok_valid    FIFO head holds a token
//   tok_ready    consumer accepts the head
//   tok_kind     0 digit, 1 operator, 2 equals
//   tok_value    digit value / op_sel / 0
//   tok_char     LCD character code
//   overflow     sticky, a token was dropped on a full FIFO
//   multi_press  one-clk pulse when several press edges shared one sample
//
// Handshake: a token transfers on every rising clk edge where tok_valid and
// tok_ready are both high. While tok_valid is high and tok_ready is low, the
// tok_* outputs hold steady. tok_ready while tok_valid is low is ignored.
//
// Optional build macro: KEYPAD_AUTO_REPEAT_EN adds auto-repeat of held digit
// keys (REP_DELAY samples to the first repeat, then every REP_PERIOD).
//
// Timing: the sample_en edge that flips a debounced level registers the
// press edges; the token is encoded and pushed on the following clk, so it
// appears on tok_* one clk after that sample_en edge.

module keypad_token_encoder #(
  parameter int DEB_SAMPLES = 4,
  parameter int FIFO_DEPTH  = 2,
  parameter int REP_DELAY   = 50,
  parameter int REP_PERIOD  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [11:0] sw,
  input  logic [2:0]  op_sel,
  output logic        tok_valid,
  input  logic        tok_ready,
  output logic [1:0]  tok_kind,
  output logic [3:0]  tok_value,
  output logic [7:0]  tok_char,
  output logic        overflow,
  output logic        multi_press
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  // ---------------- Debounce ----------------
  logic [11:0] r_lvl;
  logic [3:0]  r_cnt [12];
  logic [11:0] w_edge;
  logic [11:0] r_edge;

  // A press edge is the sample on which a 0 level has seen its final
  // differing sample and is about to flip to 1.
  always_comb begin
    w_edge = '0;
    for (int i = 0; i < 12; i++) begin
      w_edge[i] = sample_en && sw[i] && !r_lvl[i] &&
                  (r_cnt[i] == 4'(DEB_SAMPLES - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl  <= '0;
      r_edge <= '0;
      for (int i = 0; i < 12; i++) r_cnt[i] <= '0;
    end else begin
      r_edge <= w_edge;
      if (sample_en) begin
        for (int i = 0; i < 12; i++) begin
          if (sw[i] != r_lvl[i]) begin
            if (r_cnt[i] == 4'(DEB_SAMPLES - 1)) begin
              r_lvl[i] <= ~r_lvl[i];
              r_cnt[i] <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + 4'd1;
            end
          end else begin
            r_cnt[i] <= '0;
          end
        end
      end
    end
  end

  // ---------------- Encoder ----------------
  logic [3:0]  w_win;
  logic        w_any;
  logic        w_gen;
  logic [13:0] w_edge_tok;   // {kind, value, char}
  logic [7:0]  w_op_char;

  always_comb begin
    w_win = '0;
    // Descending scan so the lowest-index edge is the last assignment.
    for (int i = 11; i >= 0; i--) begin
      if (r_edge[i]) w_win = 4'(i);
    end
  end

  assign w_any = |r_edge;

  always_comb begin
    w_op_char = 8'h00;
    case (op_sel)
      3'd0: w_op_char = 8'h2B;
      3'd1: w_op_char = 8'h2D;
      3'd2: w_op_char = 8'hD7;
      3'd3: w_op_char = 8'h2F;
      3'd4: w_op_char = 8'hF7;
      3'd5: w_op_char = 8'h5E;
      3'd6: w_op_char = 8'h21;
      default: w_op_char = 8'h00;
    endcase
  end

  always_comb begin
    w_gen      = 1'b1;
    w_edge_tok = '0;
    if (w_win == 4'd10) begin
      w_edge_tok = {2'd1, 1'b0, op_sel, w_op_char};
      w_gen      = (op_sel != 3'd7);   // reserved operator makes no token
    end else if (w_win == 4'd11) begin
      w_edge_tok = {2'd2, 4'd0, 8'h3D};
    end else begin
      w_edge_tok = {2'd0, w_win, 8'h30 + {4'h0, w_win}};
    end
  end

  // ---------------- Auto repeat ----------------
  logic        w_rep_push;
  logic [13:0] w_rep_tok;

`ifdef KEYPAD_AUTO_REPEAT_EN
  logic        r_hold_act;
  logic [3:0]  r_hold_key;
  logic [15:0] r_hold_cnt;
  logic        r_hold_first;
  logic [15:0] w_hold_tgt;
  logic        w_hold_hit;

  assign w_hold_tgt = r_hold_first ? 16'(REP_DELAY) : 16'(REP_PERIOD);
  assign w_hold_hit = (r_hold_cnt + 16'd1) == w_hold_tgt;
  assign w_rep_push = r_hold_act && sample_en && r_lvl[r_hold_key] &&
                      w_hold_hit && !w_any;
  assign w_rep_tok  = {2'd0, r_hold_key, 8'h30 + {4'h0, r_hold_key}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_act   <= 1'b0;
      r_hold_key   <= '0;
      r_hold_cnt   <= '0;
      r_hold_first <= 1'b1;
    end else if (w_any) begin
      // Any new press restarts tracking; only digits are tracked.
      r_hold_act   <= (w_win < 4'd10);
      r_hold_key   <= w_win;
      r_hold_cnt   <= '0;
      r_hold_first <= 1'b1;
    end else if (r_hold_act && sample_en) begin
      if (!r_lvl[r_hold_key]) begin
        r_hold_act <= 1'b0;
      end else if (w_hold_hit) begin
        r_hold_cnt   <= '0;
        r_hold_first <= 1'b0;
      end else begin
        r_hold_cnt <= r_hold_cnt + 16'd1;
      end
    end
  end
`else
  assign w_rep_push = 1'b0;
  assign w_rep_tok  = '0;
`endif

  // ---------------- Token FIFO ----------------
  logic [13:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_multi;
  logic          w_push;
  logic [13:0]   w_push_tok;
  logic          w_pop;
  logic          w_full;
  logic          w_accept;

  assign w_push     = (w_any && w_gen) || w_rep_push;
  assign w_push_tok = w_any ? w_edge_tok : w_rep_tok;
  assign w_pop      = tok_valid && tok_ready;
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  // A pop in the same clk frees the slot, so a full FIFO still accepts.
  assign w_accept   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_multi <= w_any && ((r_edge & (r_edge - 12'd1)) != 12'd0);
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_accept) begin
        r_mem[r_wr] <= w_push_tok;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign tok_valid   = (r_count != '0);
  assign tok_kind    = r_mem[r_rd][13:12];
  assign tok_value   = r_mem[r_rd][11:8];
  assign tok_char    = r_mem[r_rd][7:0];
  assign overflow    = r_ovf;
  assign multi_press = r_multi;

endmodule

// File: tb/tb_keypad_token_encoder.sv
// Directed testbench for keypad_token_encoder (default build, no auto repeat).
module tb_keypad_token_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic [11:0] sw = '0;
  logic [2:0]  op_sel = '0;
  logic        tok_valid;
  logic        tok_ready = 1'b0;
  logic [1:0]  tok_kind;
  logic [3:0]  tok_value;
  logic [7:0]  tok_char;
  logic        overflow;
  logic        multi_press;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_token_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .sw          (sw),
    .op_sel      (op_sel),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .tok_kind    (tok_kind),
    .tok_value   (tok_value),
    .tok_char    (tok_char),
    .overflow    (overflow),
    .multi_press (multi_press)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // All driving happens 1 ns after a rising edge; checks happen there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sample(input logic [11:0] v);
    sw        = v;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  // DEB_SAMPLES consecutive samples of a value, then the push clk.
  task automatic press(input logic [11:0] v);
    for (int i = 0; i < 4; i++) do_sample(v);
    tick();
  endtask

  task automatic release_all();
    for (int i = 0; i < 4; i++) do_sample(12'h000);
    tick();
  endtask

  task automatic pop();
    tok_ready = 1'b1;
    tick();
    tok_ready = 1'b0;
  endtask

  task automatic check_tok(input string tag, input logic [1:0] k,
                           input logic [3:0] v, input logic [7:0] c);
    check({tag, "_valid"}, {31'd0, tok_valid}, 32'd1);
    check({tag, "_kind"},  {30'd0, tok_kind},  {30'd0, k});
    check({tag, "_value"}, {28'd0, tok_value}, {28'd0, v});
    check({tag, "_char"},  {24'd0, tok_char},  {24'd0, c});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_valid", {31'd0, tok_valid}, 32'd0);
    check("rst_kind",  {30'd0, tok_kind},  32'd0);
    check("rst_value", {28'd0, tok_value}, 32'd0);
    check("rst_char",  {24'd0, tok_char},  32'd0);
    check("rst_ovf",   {31'd0, overflow},  32'd0);
    check("rst_multi", {31'd0, multi_press}, 32'd0);
    rst = 1'b0;
    tick();

    // digit 3: not visible right after the 4th sample, visible 1 clk later
    for (int i = 0; i < 4; i++) do_sample(12'h008);
    check("d3_early", {31'd0, tok_valid}, 32'd0);
    tick();
    check_tok("d3", 2'd0, 4'd3, 8'h33);
    pop();
    check("d3_popped", {31'd0, tok_valid}, 32'd0);
    release_all();
    check("d3_release_notok", {31'd0, tok_valid}, 32'd0);

    // sw[5] bounce 1,0,1,1,1 then a 4th 1; changes without sample_en ignored
    do_sample(12'h020);
    do_sample(12'h000);
    do_sample(12'h020);
    do_sample(12'h020);
    do_sample(12'h020);
    sw = 12'h000;
    repeat (3) tick();
    sw = 12'h020;
    tick();
    check("bounce_notok", {31'd0, tok_valid}, 32'd0);
    do_sample(12'h020);
    tick();
    check_tok("d5", 2'd0, 4'd5, 8'h35);
    pop();
    release_all();

    // operator with op_sel=2
    op_sel = 3'd2;
    press(12'h400);
    check_tok("op2", 2'd1, 4'd2, 8'hD7);
    pop();
    release_all();

    // operator with op_sel=4
    op_sel = 3'd4;
    press(12'h400);
    check_tok("op4", 2'd1, 4'd4, 8'hF7);
    pop();
    release_all();

    // reserved op_sel=7: no token, no overflow
    op_sel = 3'd7;
    press(12'h400);
    tick();
    check("op7_notok", {31'd0, tok_valid}, 32'd0);
    check("op7_ovf",   {31'd0, overflow},  32'd0);
    release_all();

    // simultaneous 2 and 7: value 2 wins, multi_press pulses one clk
    for (int i = 0; i < 4; i++) do_sample(12'h084);
    check("multi_early", {31'd0, multi_press}, 32'd0);
    tick();
    check("multi_pulse", {31'd0, multi_press}, 32'd1);
    check_tok("multi", 2'd0, 4'd2, 8'h32);
    tick();
    check("multi_clear", {31'd0, multi_press}, 32'd0);
    pop();
    check("multi_one_tok", {31'd0, tok_valid}, 32'd0);
    release_all();

    // equals held long: only one token
    press(12'h800);
    check_tok("eq", 2'd2, 4'd0, 8'h3D);
    pop();
    for (int i = 0; i < 12; i++) do_sample(12'h800);
    tick();
    check("eq_hold_one", {31'd0, tok_valid}, 32'd0);
    release_all();

    // pop on empty ignored, then digit 0
    pop();
    press(12'h001);
    check_tok("d0", 2'd0, 4'd0, 8'h30);
    pop();
    release_all();

    // overflow: 1, 2 kept, 4 dropped
    press(12'h002);
    release_all();
    press(12'h004);
    release_all();
    check("ovf_before", {31'd0, overflow}, 32'd0);
    press(12'h010);
    release_all();
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check_tok("fifo_h1", 2'd0, 4'd1, 8'h31);
    pop();
    check_tok("fifo_h2", 2'd0, 4'd2, 8'h32);
    pop();
    check("fifo_empty", {31'd0, tok_valid}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // push and pop in the same clk on a full FIFO
    press(12'h040);          // 6
    release_all();
    press(12'h080);          // 7, FIFO now full
    release_all();
    for (int i = 0; i < 4; i++) do_sample(12'h100);   // 8 edge registered
    tok_ready = 1'b1;        // pop 6 on the clk that pushes 8
    tick();
    tok_ready = 1'b0;
    check_tok("fullpp_h7", 2'd0, 4'd7, 8'h37);
    pop();
    check_tok("fullpp_h8", 2'd0, 4'd8, 8'h38);
    pop();
    check("fullpp_empty", {31'd0, tok_valid}, 32'd0);
    release_all();

    // reset mid-operation with sw[9] held through it
    press(12'h200);
    check("pre_rst_valid", {31'd0, tok_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, tok_valid}, 32'd0);
    check("mid_rst_ovf",   {31'd0, overflow},  32'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) do_sample(12'h200);
    tick();
    check("post_rst_notok", {31'd0, tok_valid}, 32'd0);
    do_sample(12'h200);
    tick();
    check_tok("post_rst_d9", 2'd0, 4'd9, 8'h39);
    pop();
    release_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_token_encoder.md
Name: keypad_token_encoder

Overview:
- Upstream input stage of the calculator datapath. Debounces the 12 push switches and detects press edges.
- Encodes each press into a token (kind, BCD value, LCD character code) and buffers tokens in a 2-entry FIFO.
- The calculator core pops tokens with a valid/ready handshake and assembles operands and operators for the LCD line builder.

Parameters:
- DEB_SAMPLES, 4, consecutive identical samples needed before a switch's debounced level changes (range 2..15).
- FIFO_DEPTH, 2, token buffer depth (power of 2, 2 or 4).
- REP_DELAY, 50, AUTO_REPEAT_EN only: sample ticks a key is held before the first repeat.
- REP_PERIOD, 10, AUTO_REPEAT_EN only: sample ticks between subsequent repeats.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sample_en  in  1  single-clk strobe; debounce sampling advances only on cycles where it is high (100 Hz rate)
- sw  in  12  raw push switches, active-high; [9:0] digits 0-9, [10] operator, [11] equals
- op_sel  in  3  DIP-selected operator, captured when the operator token is created
- tok_valid  out  1  FIFO head holds a token
- tok_ready  in  1  consumer accepts head when tok_valid && tok_ready on a clk edge
- tok_kind  out  2  0 digit, 1 operator, 2 equals, 3 unused
- tok_value  out  4  digit BCD value; op_sel value for operators; 0 for equals
- tok_char  out  8  LCD character code of the token
- overflow  out  1  sticky; set when a token is dropped because the FIFO is full
- multi_press  out  1  one-clk pulse when two or more press edges occur in the same sample

Behaviour:
- Reset (async, immediate):
  - Debounced levels = 0; all debounce counters = 0.
  - FIFO empty, so tok_valid = 0. tok_kind, tok_value and tok_char = 0.
  - overflow = 0, multi_press = 0.
- Debounce, per switch, on a sample_en cycle:
  - If raw ≠ debounced level, the counter increments. When it reaches DEB_SAMPLES, the level flips and the counter clears.
  - If raw = debounced level, the counter clears.
- Press edge: debounced level goes 0→1. Release edges produce no token.
- Encoding: on a sample_en cycle with at least one press edge, the lowest-index edge wins. The other edges are discarded and multi_press pulses.
  - Digit n → kind 0, value n, char 0x30+n.
  - sw[10] → kind 1, value op_sel, char per op_sel: 0 '+' 0x2B, 1 '-' 0x2D, 2 × 0xD7, 3 '/' 0x2F, 4 ÷rem 0xF7, 5 '^' 0x5E, 6 '!' 0x21.
  - op_sel 7 is reserved: no token is generated (not counted as overflow).
  - sw[11] → kind 2, value 0, char 0x3D.
- Latency: token visible on tok_* exactly 1 clk after the sample_en edge that produced the debounced press, provided the FIFO was empty.
- FIFO:
  - Registered head outputs; tok_* hold their value while tok_valid && !tok_ready.
  - Push and pop in the same clk when full is allowed: the pop frees the slot and the push is accepted.
  - Push when full and not popping: the token is dropped and overflow is set. overflow clears only on rst.
  - Pop when empty is ignored.
- sw changes between sample_en strobes have no effect.
- Holding a key generates exactly one token (unless AUTO_REPEAT_EN).
- Reset mid-operation discards buffered tokens. A key held through reset deassertion debounces as a fresh press after DEB_SAMPLES samples.

Optional Feature:
- KEYPAD_AUTO_REPEAT_EN defined:
  - The winning key is tracked by a hold counter that runs on sample_en.
  - Digits only: if the key is still held after REP_DELAY samples, the same token is pushed again, then every REP_PERIOD samples until release.
  - Operator and equals never repeat.
  - A new press edge restarts tracking on the new key.
- Macro undefined: no hold counter logic exists; one token per press.

Test Plan:
- Reset, then raise sw[3] steady for 4 samples → after the 4th sample_en, 1 clk later tok_valid=1, kind 0, value 3, tok_char 0x33. tok_ready=1 → tok_valid=0 next clk.
- sw[5] bounces 1,0,1,1,1,1 across samples → a single token (value 5) only after 4 consecutive 1s; no token on the bounce.
- op_sel=2, press sw[10] → kind 1, value 2, char 0xD7. op_sel=7, press sw[10] → no token, overflow stays 0.
- sw[2] and sw[7] both debounce in the same sample → one token with value 2, multi_press pulses one clk.
- tok_ready=0, press digits 1, 2, 4 sequentially → FIFO holds 1,2; 4 is dropped and overflow=1. Pop twice → 1 then 2, then tok_valid=0.
- With KEYPAD_AUTO_REPEAT_EN, REP_DELAY=50, REP_PERIOD=10: hold sw[9] for 80 samples after debounce → tokens at hold samples 0, 50, 60, 70, 80. Hold sw[11] → only one 0x3D token.
